// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU operation codes and EX FSM states.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    EX_IDLE,
    EX_MUL
  } ex_state_t;

endpackage

// File: rtl/ex_mem_stage_seq_multiplier.sv
// Iterative shift-add multiplier, one partial-product step per cycle.
// The product is presented combinationally during the final iteration so the
// caller can register it on the completing edge.
module seq_multiplier #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_d;

  // Accumulate the current partial product.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Iteration state: load on start, drop on flush, otherwise step until the last count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_d;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM boundary register.
// Optional feature macro MUL_UNIT_EN: ALUOp 111 runs an iterative multiplier
// that stalls upstream; without it ALUOp 111 yields 0 in a single cycle.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_flush,
  input  logic [DATA_W-1:0]     in_read_data1,
  input  logic [DATA_W-1:0]     in_read_data2,
  input  logic [DATA_W-1:0]     in_extended_bits,
  input  logic [DATA_W-1:0]     in_new_pc_value,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_20_16,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_15_11,
  input  logic                  in_RegDst,
  input  logic                  in_RegWrite,
  input  logic                  in_ALUSrc,
  input  logic                  in_MemWrite,
  input  logic                  in_MemRead,
  input  logic                  in_MemToReg,
  input  logic                  in_PCSrc,
  input  logic [2:0]            in_ALUOp,
  output logic                  stall_req,
  output logic                  valid,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  zero,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  MemToReg,
  output logic                  PCSrc
);

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] res_sel;
  logic              take;
  logic              is_mul;
  logic              issue;

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     branch_target_q, branch_target_d;
  logic                  zero_q, zero_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  pc_src_q, pc_src_d;

  assign take   = in_valid & ~in_flush;
  assign is_mul = (in_ALUOp == ALU_MUL);

  // Operand select and single-cycle ALU.
  always_comb begin
    op_b = in_ALUSrc ? in_extended_bits : in_read_data2;
    case (in_ALUOp)
      ALU_ADD: alu_res = in_read_data1 + op_b;
      ALU_SUB: alu_res = in_read_data1 - op_b;
      ALU_AND: alu_res = in_read_data1 & op_b;
      ALU_OR:  alu_res = in_read_data1 | op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(in_read_data1) < $signed(op_b))};
      ALU_NOR: alu_res = ~(in_read_data1 | op_b);
      ALU_SLL: alu_res = op_b << in_extended_bits[10:6];
      default: alu_res = '0;
    endcase
  end

`ifdef MUL_UNIT_EN
  ex_state_t         state_q, state_d;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .flush_i   (in_flush),
    .a_i       (in_read_data1),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Multiply sequencing: entry, stall generation, completion and flush abort.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    stall_req = 1'b0;
    issue     = 1'b0;
    res_sel   = alu_res;
    case (state_q)
      EX_IDLE: begin
        stall_req = in_valid & is_mul;
        issue     = take & ~is_mul;
        if (take && is_mul) begin
          state_d   = EX_MUL;
          mul_start = 1'b1;
        end
      end
      EX_MUL: begin
        res_sel   = mul_product;
        stall_req = mul_busy & ~mul_done;
        if (in_flush) begin
          state_d = EX_IDLE;
        end else if (mul_done) begin
          state_d = EX_IDLE;
          issue   = 1'b1;
        end
      end
      default: state_d = EX_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  // Without the multiplier every op completes in one cycle and nothing stalls.
  always_comb begin
    stall_req = 1'b0;
    issue     = take;
    res_sel   = alu_res;
  end
`endif

  // Next EX/MEM contents; control bits are gated so bubbles and kills carry no side effects.
  always_comb begin
    valid_d         = issue;
    alu_result_d    = res_sel;
    zero_d          = (res_sel == '0);
    write_reg_d     = in_RegDst ? in_instr_bits_15_11 : in_instr_bits_20_16;
    write_data_d    = in_read_data2;
    branch_target_d = in_new_pc_value + (in_extended_bits << 2);
    reg_write_d     = in_RegWrite & issue;
    mem_write_d     = in_MemWrite & issue;
    mem_read_d      = in_MemRead & issue;
    mem_to_reg_d    = in_MemToReg & issue;
    pc_src_d        = in_PCSrc & zero_d & issue;
  end

  // EX/MEM boundary register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      alu_result_q    <= '0;
      write_data_q    <= '0;
      write_reg_q     <= '0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      pc_src_q        <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      alu_result_q    <= alu_result_d;
      write_data_q    <= write_data_d;
      write_reg_q     <= write_reg_d;
      branch_target_q <= branch_target_d;
      zero_q          <= zero_d;
      reg_write_q     <= reg_write_d;
      mem_write_q     <= mem_write_d;
      mem_read_q      <= mem_read_d;
      mem_to_reg_q    <= mem_to_reg_d;
      pc_src_q        <= pc_src_d;
    end
  end

  assign valid         = valid_q;
  assign alu_result    = alu_result_q;
  assign write_data    = write_data_q;
  assign write_reg     = write_reg_q;
  assign branch_target = branch_target_q;
  assign zero          = zero_q;
  assign RegWrite      = reg_write_q;
  assign MemWrite      = mem_write_q;
  assign MemRead       = mem_read_q;
  assign MemToReg      = mem_to_reg_q;
  assign PCSrc         = pc_src_q;

endmodule
